// File: rtl/uart_tx_arb_pkg.sv
// Shared constants and types for the UART transmit arbiter: FSM states,
// requester IDs, the grant payload and the arbitration helper.
package uart_tx_arb_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  typedef enum logic {
    REQ_BOOT = 1'b0,
    REQ_CPU  = 1'b1
  } req_e;

  typedef struct packed {
    req_e              id;
    logic [DATA_W-1:0] data;
  } tx_req_t;

  // Boot mode gives the bootloader strict priority; otherwise a tie goes to rr_next.
  function automatic req_e arb_pick(input logic boot_mode, input logic boot_full,
                                    input logic cpu_full, input req_e rr_next);
    req_e pick;
    if (!boot_mode && boot_full && cpu_full) pick = rr_next;
    else                                     pick = boot_full ? REQ_BOOT : REQ_CPU;
    return pick;
  endfunction

endpackage

// File: rtl/tx_hold_slot.sv
// One-byte hold slot for a single requester: accepts on valid & ready and
// empties when the arbiter frees it after the byte is loaded.
module tx_hold_slot
  import uart_tx_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              free_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // free_i only arrives while full, so it can never collide with an accept.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (free_i) begin
      full_d = 1'b0;
    end else if (valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready_o = ~full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates bootloader and CPU byte requests onto a single UART transmitter,
// with a per-byte tx_done watchdog and a sticky timeout flag.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8192,
  parameter int unsigned TO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              booting,
  input  logic              boot_valid,
  input  logic [DATA_W-1:0] boot_data,
  output logic              boot_ready,
  input  logic              cpu_valid,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  output logic              owner,
  output logic              busy,
  input  logic              err_clr,
  output logic              timeout_err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d;
  req_e              owner_q, owner_d;
  req_e              rr_q, rr_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]   cnt_inc;
  tx_req_t           win;

  logic              boot_full, cpu_full, boot_free, cpu_free;
  logic [DATA_W-1:0] boot_slot_data, cpu_slot_data;

  assign boot_free = (state_q == ST_LOAD) && (owner_q == REQ_BOOT);
  assign cpu_free  = (state_q == ST_LOAD) && (owner_q == REQ_CPU);

  tx_hold_slot u_boot_slot (
    .clk_i   (clk),
    .rst_ni  (rst),
    .valid_i (boot_valid),
    .data_i  (boot_data),
    .free_i  (boot_free),
    .ready_o (boot_ready),
    .full_o  (boot_full),
    .data_o  (boot_slot_data)
  );

  tx_hold_slot u_cpu_slot (
    .clk_i   (clk),
    .rst_ni  (rst),
    .valid_i (cpu_valid),
    .data_i  (cpu_data),
    .free_i  (cpu_free),
    .ready_o (cpu_ready),
    .full_o  (cpu_full),
    .data_o  (cpu_slot_data)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    owner_d   = owner_q;
    rr_d      = rr_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + TO_W'(1);
    win.id    = arb_pick(booting, boot_full, cpu_full, rr_q);
    win.data  = (win.id == REQ_BOOT) ? boot_slot_data : cpu_slot_data;

    if (err_clr) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (boot_full || cpu_full) begin
          state_d   = ST_LOAD;
          tx_wr_d   = 1'b1;
          tx_data_d = win.data;
          owner_d   = win.id;
          rr_d      = (win.id == REQ_BOOT) ? REQ_CPU : REQ_BOOT;
        end
      end
      ST_LOAD: begin
        state_d = ST_BUSY;
        cnt_d   = '0;
      end
      ST_BUSY: begin
        cnt_d = cnt_inc;
        // tx_done beats a coincident timeout; the LOAD+BUSY window spans TIMEOUT cycles.
        if (tx_done) begin
          state_d = ST_IDLE;
        end else if (cnt_inc == TO_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      owner_q   <= REQ_BOOT;
      rr_q      <= REQ_CPU;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_wr       = tx_wr_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: a per-cycle vector table followed by
// hand-written round-robin, timeout, tx_done/timeout race and reset sequences.
module tb_uart_tx_arb;

  localparam int unsigned TO = 16;

  logic       clk;
  logic       rst;
  logic       booting;
  logic       boot_valid;
  logic [7:0] boot_data;
  logic       boot_ready;
  logic       cpu_valid;
  logic [7:0] cpu_data;
  logic       cpu_ready;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;
  logic       owner;
  logic       busy;
  logic       err_clr;
  logic       timeout_err;

  uart_tx_arb #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .booting     (booting),
    .boot_valid  (boot_valid),
    .boot_data   (boot_data),
    .boot_ready  (boot_ready),
    .cpu_valid   (cpu_valid),
    .cpu_data    (cpu_data),
    .cpu_ready   (cpu_ready),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_done     (tx_done),
    .owner       (owner),
    .busy        (busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle; exp = {tx_wr, tx_data, owner, busy, boot_ready, cpu_ready, timeout_err}
  // as seen in the following cycle.
  typedef struct {
    logic        rst;
    logic        bt;
    logic        bv;
    logic [7:0]  bd;
    logic        cv;
    logic [7:0]  cd;
    logic        dn;
    logic        clr;
    logic [13:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic r, input logic bt, input logic bv, input logic [7:0] bd,
                              input logic cv, input logic [7:0] cd, input logic dn, input logic clr,
                              input logic wr, input logic [7:0] d, input logic own, input logic bsy,
                              input logic br, input logic cr, input logic err);
    vec_t v;
    v.rst = r;  v.bt = bt; v.bv = bv; v.bd = bd;
    v.cv  = cv; v.cd = cd; v.dn = dn; v.clr = clr;
    v.exp = {wr, d, own, bsy, br, cr, err};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int   n_rr;
  int   done_in;
  logic prev_wr;

  initial begin
    rst = 1'b0; booting = 1'b0; boot_valid = 1'b0; boot_data = 8'h00;
    cpu_valid = 1'b0; cpu_data = 8'h00; tx_done = 1'b0; err_clr = 1'b0;

    //             rst bt bv bd     cv cd     dn clr  wr data   own bsy br cr err
    tbl[0]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 1, 1, 0);
    tbl[1]  = mk(1, 0, 0, 8'h00, 1, 8'h41, 0, 0,  0, 8'h00, 0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0,  1, 8'h41, 1, 1, 1, 0, 0);
    tbl[3]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 8'h41, 1, 1, 1, 1, 0);
    tbl[4]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0,  0, 8'h41, 1, 1, 1, 1, 0);
    tbl[5]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 8'h41, 1, 0, 1, 1, 0);
    tbl[6]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 8'h41, 1, 0, 1, 1, 0);
    tbl[7]  = mk(1, 1, 1, 8'hA5, 1, 8'h3C, 0, 0,  0, 8'h41, 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0,  1, 8'hA5, 0, 1, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0,  0, 8'hA5, 0, 1, 1, 0, 0);
    tbl[10] = mk(1, 1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 8'hA5, 0, 0, 1, 0, 0);
    tbl[11] = mk(1, 1, 0, 8'h00, 0, 8'h00, 1, 0,  1, 8'h3C, 1, 1, 1, 0, 0);
    tbl[12] = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0,  0, 8'h3C, 1, 1, 1, 1, 0);
    tbl[13] = mk(1, 1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 8'h3C, 1, 0, 1, 1, 0);
    tbl[14] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 8'h3C, 1, 0, 1, 1, 0);

    for (int i = 0; i < NVEC; i++) begin
      rst = tbl[i].rst; booting = tbl[i].bt;
      boot_valid = tbl[i].bv; boot_data = tbl[i].bd;
      cpu_valid = tbl[i].cv; cpu_data = tbl[i].cd;
      tx_done = tbl[i].dn; err_clr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d", i),
          32'({tx_wr, tx_data, owner, busy, boot_ready, cpu_ready, timeout_err}),
          32'(tbl[i].exp));
    end
    tx_done = 1'b0;

    // Round-robin with both slots kept full; last grant was cpu, so boot goes first.
    booting = 1'b0; boot_valid = 1'b1; boot_data = 8'hB0; cpu_valid = 1'b1; cpu_data = 8'hC1;
    n_rr = 0; done_in = -1; prev_wr = 1'b0;
    for (int cyc = 0; cyc < 100 && n_rr < 4; cyc++) begin
      tx_done = (done_in == 0);
      if (done_in >= 0) done_in--;
      step();
      if (tx_wr) begin
        chk($sformatf("rr_gap%0d", n_rr), 32'(prev_wr), 32'(0));
        chk($sformatf("rr_owner%0d", n_rr), 32'(owner), 32'(n_rr % 2));
        chk($sformatf("rr_data%0d", n_rr), 32'(tx_data), (n_rr % 2 == 1) ? 32'hC1 : 32'hB0);
        n_rr++;
        done_in = 3;
      end
      prev_wr = tx_wr;
    end
    chk("rr_bytes", 32'(n_rr), 32'(4));
    boot_valid = 1'b0; cpu_valid = 1'b0; tx_done = 1'b0;

    // Timeout with no tx_done, sticky flag, then clear.
    rst = 1'b0; step(); rst = 1'b1;
    cpu_valid = 1'b1; cpu_data = 8'h55; step(); cpu_valid = 1'b0; step();
    chk("to_load", 32'({tx_wr, tx_data}), 32'({1'b1, 8'h55}));
    repeat (TO - 1) step();
    chk("to_busy_before", 32'({busy, timeout_err}), 32'(2'b10));
    step();
    chk("to_fired", 32'({busy, timeout_err}), 32'(2'b01));
    tx_done = 1'b1; step(); tx_done = 1'b0;
    chk("to_sticky", 32'({busy, timeout_err}), 32'(2'b01));
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("to_clr", 32'(timeout_err), 32'(0));

    // err_clr coinciding with a new timeout: set wins.
    cpu_valid = 1'b1; cpu_data = 8'h66; step(); cpu_valid = 1'b0; step();
    chk("to2_load", 32'({tx_wr, tx_data}), 32'({1'b1, 8'h66}));
    repeat (TO - 1) step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("to2_set_wins", 32'({busy, timeout_err}), 32'(2'b01));

    // tx_done on the timeout-limit cycle, with a boot byte queued behind.
    rst = 1'b0; step(); rst = 1'b1;
    cpu_valid = 1'b1; cpu_data = 8'h11; step(); cpu_valid = 1'b0; step();
    chk("race_load", 32'({tx_wr, tx_data, owner}), 32'({1'b1, 8'h11, 1'b1}));
    boot_valid = 1'b1; boot_data = 8'h22; step(); boot_valid = 1'b0;
    repeat (TO - 2) step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    chk("race_no_err", 32'({tx_wr, busy, timeout_err}), 32'(3'b000));
    step();
    chk("race_next_load", 32'({tx_wr, tx_data, owner}), 32'({1'b1, 8'h22, 1'b0}));

    // Reset 3 cycles after LOAD with a cpu byte queued; stale tx_done afterwards.
    cpu_valid = 1'b1; cpu_data = 8'h33; step(); cpu_valid = 1'b0;
    step(); step();
    chk("rst_pre", 32'({busy, cpu_ready}), 32'(2'b10));
    rst = 1'b0; step();
    chk("rst_state", 32'({tx_wr, busy, boot_ready, cpu_ready, tx_data, owner, timeout_err}),
        32'({1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0}));
    rst = 1'b1; tx_done = 1'b1; step(); tx_done = 1'b0;
    chk("rst_stale_done", 32'({tx_wr, busy, boot_ready, cpu_ready}), 32'(4'b0011));
    step(); step();
    chk("rst_quiet", 32'({tx_wr, busy}), 32'(2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8192: cycles to wait for tx_done before abandoning a byte.
REQ-002 SHALL have parameter TO_W, default 16: timeout counter width; TIMEOUT < 2**TO_W.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port booting, input, 1: boot mode; bootloader has strict priority.
REQ-006 SHALL have ports boot_valid (in, 1), boot_data (in, 8), boot_ready (out, 1): bootloader byte request.
REQ-007 SHALL have ports cpu_valid (in, 1), cpu_data (in, 8), cpu_ready (out, 1): CPU io byte request.
REQ-008 SHALL have port tx_data, output, 8: byte to the UART transmitter.
REQ-009 SHALL have port tx_wr, output, 1: one-cycle transmit strobe to the UART.
REQ-010 SHALL have port tx_done, input, 1: one-cycle pulse from the UART at end of byte.
REQ-011 SHALL have port owner, output, 1: 0 = boot, 1 = cpu; requester of the current or last byte.
REQ-012 SHALL have port busy, output, 1: high in LOAD and BUSY.
REQ-013 SHALL have ports err_clr (in, 1) and timeout_err (out, 1): sticky timeout flag and its clear.

Function
REQ-014 Each requester SHALL have a 1-byte hold slot; the slot accepts on valid & ready; ready = ~slot_full.
REQ-015 The FSM SHALL have states IDLE, LOAD and BUSY.
REQ-016 IDLE -> LOAD SHALL occur on the cycle after any slot is full; the winner is latched into a tx_data register and owner.
REQ-017 Arbitration with booting=1 SHALL select boot whenever its slot is full; cpu is selected only if the boot slot is empty.
REQ-018 Arbitration with booting=0 SHALL be round-robin: if both slots are full, the requester not granted last wins; a single full slot always wins.
REQ-019 The LOAD state SHALL last exactly 1 cycle: tx_wr=1, the winning slot is freed, then the FSM moves to BUSY.
REQ-020 A freed slot's ready SHALL be high on the cycle after LOAD; a new byte may be accepted then; throughput is one byte per UART frame.
REQ-021 tx_data SHALL be stable from LOAD until the FSM leaves BUSY.
REQ-022 BUSY -> IDLE SHALL occur on tx_done; if a slot is full, the next LOAD follows 1 cycle later, with no back-to-back tx_wr.
REQ-023 tx_done received in IDLE or LOAD SHALL be ignored.
REQ-024 The timeout counter SHALL clear on LOAD and increment in BUSY; when the count reaches TIMEOUT-1 without tx_done, the FSM SHALL go to IDLE and set timeout_err. The dropped byte is not retried.
REQ-025 timeout_err SHALL stay set until err_clr; if err_clr and a new timeout occur in the same cycle, set wins.
REQ-026 A change of booting mid-byte SHALL NOT abort the byte; it affects only the next arbitration.
REQ-027 If tx_done and a timeout occur in the same cycle, tx_done wins and timeout_err is not set.
REQ-028 A pending cpu byte while booting=1 SHALL remain held, not dropped, and is sent once the boot slot is empty.

Reset
REQ-029 On rst=0 at a clk edge, all state SHALL clear: FSM=IDLE, both slots empty, tx_wr=0, tx_data=0, owner=0, busy=0, timeout_err=0, round-robin pointer=cpu next, timeout counter=0.
REQ-030 Reset asserted mid-byte SHALL abort it; tx_wr=0 from the cycle after the reset edge; both ready outputs are high on the first cycle after rst returns to 1.

Structure
REQ-031 The state encodings (IDLE=0, LOAD=1, BUSY=2) and requester IDs (BOOT=0, CPU=1) SHALL live in the shared constants include.
REQ-032 The hold slot SHALL be a sub-module tx_hold_slot (data register, full flag, ready, free input), instantiated twice.
REQ-033 All outputs SHALL be registered except boot_ready and cpu_ready, which are the inverted full flags.

Verification
REQ-034 booting=0, cpu sends 0x41 -> tx_wr exactly 2 cycles after the accept cycle with tx_data=0x41, owner=1; busy stays high until tx_done.
REQ-035 booting=1, boot 0xA5 and cpu 0x3C both presented in the same cycle -> 0xA5 sent first, 0x3C after its tx_done; exactly 2 tx_wr pulses.
REQ-036 booting=0, both slots refilled continuously -> owner alternates 0,1,0,1 over 4 bytes; tx_wr never on consecutive cycles.
REQ-037 No tx_done after LOAD -> FSM returns to IDLE TIMEOUT cycles after LOAD, timeout_err=1; stays 1 until err_clr pulse, then 0.
REQ-038 rst=0 asserted in BUSY, 3 cycles after LOAD -> next cycle tx_wr=0, busy=0, both ready=1, stale tx_done ignored.
REQ-039 tx_done on the same cycle as the timeout limit -> timeout_err stays 0; a queued byte's tx_wr occurs 2 cycles later.
